// File: rtl/reg8_access_arbiter_pkg.sv
// Shared types for the reg8 access arbiter:
// command and FSM state encodings.
package reg8_access_arbiter_pkg;

  typedef enum logic [1:0] {
    CMD_LOAD   = 2'b00,
    CMD_PRESET = 2'b01,
    CMD_CLEAR  = 2'b10,
    CMD_NOP    = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/reg8_access_arbiter_if.sv
// Requester-side bus of the reg8 access arbiter:
// req/cmd/wdata in, register and status out.
interface reg8_access_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req;
  logic [2*N_REQ-1:0]     cmd;
  logic [WIDTH*N_REQ-1:0] wdata;
  logic [WIDTH-1:0]       q;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic                   busy;
  logic [IDW-1:0]         last_id;
  logic [CNT_W-1:0]       xact_cnt;

  modport master (
    output req, cmd, wdata,
    input  q, gnt, ack, busy,
    input  last_id, xact_cnt
  );

  modport slave (
    input  req, cmd, wdata,
    output q, gnt, ack, busy,
    output last_id, xact_cnt
  );
endinterface

// File: rtl/reg8_access_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req
// searching upward from ptr+1, wrapping mod N_REQ.
module reg8_access_arbiter_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             valid,
  output logic [IDW-1:0]   win
);

  int          idx;
  logic [IDW-1:0] ix;

  // Walk farthest-first so the nearest match wins.
  always_comb begin
    valid = 1'b0;
    win   = '0;
    idx   = 0;
    ix    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(ptr) + i) % N_REQ;
      ix  = IDW'(idx);
      if (req[ix]) begin
        valid = 1'b1;
        win   = ix;
      end
    end
  end

endmodule

// File: rtl/reg8_access_arbiter.sv
// Round-robin access controller for one shared
// register: grant, apply command, 4-phase ack.
module reg8_access_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  reg8_access_arbiter_if.slave bus
);
  import reg8_access_arbiter_pkg::*;

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDW-1:0] LAST = IDW'(N_REQ - 1);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  cmd_e             cmd_q, cmd_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             win_vld;
  logic [IDW-1:0]   win;
  logic [1:0]       sel_cmd;
  logic [WIDTH-1:0] sel_data;

  reg8_access_arbiter_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (win_vld),
    .win   (win)
  );

  always_comb begin
    sel_cmd  = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDW'(i) == win) begin
        sel_cmd  = bus.cmd[2*i +: 2];
        sel_data = bus.wdata[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    q_d     = q_q;
    gnt_d   = '0;
    ack_d   = '0;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          id_d    = win;
          cmd_d   = cmd_e'(sel_cmd);
          data_d  = sel_data;
          gnt_d   = N_REQ'(1) << win;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        unique case (1'b1)
          cmd_q == CMD_LOAD:   q_d = data_q;
          cmd_q == CMD_PRESET: q_d = '1;
          cmd_q == CMD_CLEAR:  q_d = '0;
          cmd_q == CMD_NOP:    q_d = q_q;
        endcase
        ack_d   = N_REQ'(1) << id_q;
        ptr_d   = id_q;
        last_d  = id_q;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!bus.req[id_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= LAST;
      id_q    <= '0;
      cmd_q   <= CMD_NOP;
      data_q  <= '0;
      q_q     <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      last_q  <= LAST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      q_q     <= q_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.last_id  = last_q;
  assign bus.xact_cnt = cnt_q;

endmodule

// File: tb/tb_reg8_access_arbiter.sv
// Bench for reg8_access_arbiter: directed stimulus,
// transaction-level model and per-cycle compare.
module tb_reg8_access_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  reg8_access_arbiter_if #(
    .N_REQ (N), .WIDTH (8), .CNT_W (8)
  ) bus ();

  reg8_access_arbiter #(
    .N_REQ (N), .WIDTH (8), .CNT_W (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: owner of the register and how many
  // edges have passed since it was granted.
  bit         started = 0;
  int         m_own = -1;
  int         m_age = 0;
  int         m_ptr = N - 1;
  logic [1:0] m_cmd = 2'b11;
  logic [7:0] m_dat = '0;
  logic [7:0] m_q   = '0;
  logic [7:0] m_cnt = '0;
  int         m_last = N - 1;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_q = '0; m_cnt = '0; m_last = N - 1;
      m_ptr = N - 1; m_own = -1; m_age = 0;
      started = 1;
    end else if (m_own < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (bus.req[c]) begin
          m_own = c;
          m_age = 0;
          m_cmd = bus.cmd[2*c +: 2];
          m_dat = bus.wdata[8*c +: 8];
          break;
        end
      end
    end else if (m_age == 0) begin
      case (m_cmd)
        2'b00:   m_q = m_dat;
        2'b01:   m_q = 8'hFF;
        2'b10:   m_q = 8'h00;
        default: ;
      endcase
      m_cnt  = m_cnt + 8'd1;
      m_last = m_own;
      m_ptr  = m_own;
      m_age  = 1;
    end else if (!bus.req[m_own]) begin
      m_own = -1;
    end else begin
      m_age = 2;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      logic [3:0] eg, ea;
      eg = (m_own >= 0 && m_age == 0)
           ? (4'b1 << m_own) : 4'b0;
      ea = (m_own >= 0 && m_age == 1)
           ? (4'b1 << m_own) : 4'b0;
      chk("m_q", 32'(bus.q), 32'(m_q));
      chk("m_gnt", 32'(bus.gnt), 32'(eg));
      chk("m_ack", 32'(bus.ack), 32'(ea));
      chk("m_busy", 32'(bus.busy), 32'(m_own >= 0));
      chk("m_last", 32'(bus.last_id), 32'(m_last));
      chk("m_cnt", 32'(bus.xact_cnt), 32'(m_cnt));
    end
  end

  task automatic set_req(int i, logic [1:0] c,
                         logic [7:0] d);
    bus.req[i]           = 1'b1;
    bus.cmd[2*i +: 2]    = c;
    bus.wdata[8*i +: 8]  = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(output int id);
    bit ok;
    id = -1;
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (bus.ack[i]) begin
          id = i;
          ok = 1;
        end
    end
    if (!ok) chk("ack_timeout", 0, 1);
  endtask

  task automatic serve(int i, logic [1:0] c,
                       logic [7:0] d);
    int id;
    @(negedge clk);
    set_req(i, c, d);
    wait_ack(id);
    chk("serve_id", 32'(id), 32'(i));
    bus.req[i] = 1'b0;
  endtask

  initial begin
    int id;
    int order[4];
    bus.req   = '0;
    bus.cmd   = '1;
    bus.wdata = '0;

    // reset then single load
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_q", 32'(bus.q), 0);
    chk("rst_last", 32'(bus.last_id), 3);
    chk("rst_cnt", 32'(bus.xact_cnt), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    set_req(0, 2'b00, 8'h13);
    @(negedge clk);
    chk("ld_gnt", 32'(bus.gnt), 32'h1);
    @(negedge clk);
    chk("ld_q", 32'(bus.q), 32'h13);
    chk("ld_ack", 32'(bus.ack), 32'h1);
    chk("ld_cnt", 32'(bus.xact_cnt), 1);
    bus.req[0] = 1'b0;
    @(negedge clk);
    chk("ld_ack_off", 32'(bus.ack), 0);
    @(negedge clk);
    chk("ld_idle", 32'(bus.busy), 0);

    // preset then clear
    do_reset();
    serve(2, 2'b01, 8'h00);
    chk("pre_q", 32'(bus.q), 32'hFF);
    serve(1, 2'b10, 8'h55);
    chk("clr_q", 32'(bus.q), 0);
    chk("clr_last", 32'(bus.last_id), 1);
    chk("clr_cnt", 32'(bus.xact_cnt), 2);

    // round robin, all four at once
    do_reset();
    @(negedge clk);
    set_req(0, 2'b00, 8'h20);
    set_req(1, 2'b00, 8'h27);
    set_req(2, 2'b00, 8'hA5);
    set_req(3, 2'b00, 8'h5A);
    for (int n = 0; n < 4; n++) begin
      wait_ack(id);
      order[n] = id;
      if (id >= 0) bus.req[id] = 1'b0;
    end
    for (int n = 0; n < 4; n++)
      chk("rr_order", 32'(order[n]), 32'(n));
    @(negedge clk);
    chk("rr_q", 32'(bus.q), 32'h5A);
    chk("rr_cnt", 32'(bus.xact_cnt), 4);

    // wrap: ptr=3, so 0 beats 3
    set_req(3, 2'b00, 8'h33);
    set_req(0, 2'b00, 8'h11);
    for (int n = 0; n < 2; n++) begin
      wait_ack(id);
      order[n] = id;
      if (id >= 0) bus.req[id] = 1'b0;
    end
    chk("wrap_first", 32'(order[0]), 0);
    chk("wrap_second", 32'(order[1]), 3);
    @(negedge clk);
    chk("wrap_q", 32'(bus.q), 32'h33);

    // held req keeps HOLD; req2 waits
    set_req(1, 2'b00, 8'h77);
    wait_ack(id);
    chk("hold_id", 32'(id), 1);
    set_req(2, 2'b00, 8'h88);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("hold_busy", 32'(bus.busy), 1);
      chk("hold_gnt", 32'(bus.gnt), 0);
    end
    bus.req[1] = 1'b0;
    wait_ack(id);
    chk("hold_next", 32'(id), 2);
    bus.req[2] = 1'b0;
    @(negedge clk);
    chk("hold_q", 32'(bus.q), 32'h88);

    // req dropped during EXEC still completes
    set_req(1, 2'b01, 8'h00);
    @(negedge clk);
    bus.req[1] = 1'b0;
    @(negedge clk);
    chk("viol_ack", 32'(bus.ack), 32'h2);
    chk("viol_q", 32'(bus.q), 32'hFF);
    @(negedge clk);
    chk("viol_idle", 32'(bus.busy), 0);

    // reset during EXEC aborts the load
    set_req(0, 2'b00, 8'hC3);
    @(negedge clk);
    chk("abort_gnt", 32'(bus.gnt), 32'h1);
    rst = 1'b1;
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_q", 32'(bus.q), 0);
    chk("abort_ack", 32'(bus.ack), 0);
    chk("abort_gnt0", 32'(bus.gnt), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    @(negedge clk);
    chk("abort_noack", 32'(bus.ack), 0);

    // counter wraps after 256 no-ops
    for (int n = 0; n < 256; n++) serve(0, 2'b11, 8'hEE);
    @(negedge clk);
    chk("wrap_cnt", 32'(bus.xact_cnt), 0);
    chk("nop_q", 32'(bus.q), 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
